// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues word-aligned data memory requests with
// byte enables over a req/ack handshake, formats load data for writeback and
// flags misaligned, illegal and timed-out accesses.
module mem_access_stage #(
    parameter int unsigned DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // Execute stage
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_wdata,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    // Data memory
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    // Writeback
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        mem_exc,
    output logic [1:0]  mem_exc_cause
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned CNT_W  = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered outputs and captured instruction fields
    logic             r_dmem_req,     w_dmem_req_nxt;
    logic             r_dmem_we,      w_dmem_we_nxt;
    logic [XLEN-1:0]  r_dmem_addr,    w_dmem_addr_nxt;
    logic [BE_W-1:0]  r_dmem_be,      w_dmem_be_nxt;
    logic [XLEN-1:0]  r_dmem_wdata,   w_dmem_wdata_nxt;
    logic             r_wb_valid,     w_wb_valid_nxt;
    logic [RD_W-1:0]  r_wb_rd,        w_wb_rd_nxt;
    logic             r_wb_reg_write, w_wb_reg_write_nxt;
    logic [XLEN-1:0]  r_wb_data,      w_wb_data_nxt;
    logic             r_mem_exc,      w_mem_exc_nxt;
    logic [1:0]       r_exc_cause,    w_exc_cause_nxt;
    logic [CNT_W-1:0] r_cnt,          w_cnt_nxt;
    logic [2:0]       r_funct3,       w_funct3_nxt;
    logic [1:0]       r_addr_lo,      w_addr_lo_nxt;
    logic [RD_W-1:0]  r_rd,           w_rd_nxt;
    logic             r_reg_write,    w_reg_write_nxt;
    logic             r_is_load,      w_is_load_nxt;

    // Decode results for the instruction presented by execute
    logic             w_is_mem;
    logic             w_illegal;
    logic             w_misaligned;
    logic [BE_W-1:0]  w_be;
    logic [XLEN-1:0]  w_lane_wdata;

    // Load formatting
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [XLEN-1:0]  w_load_data;
    logic             w_timeout_hit;

    assign ex_ready      = (r_state == S_IDLE);
    assign dmem_req      = r_dmem_req;
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_be       = r_dmem_be;
    assign dmem_wdata    = r_dmem_wdata;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_data       = r_wb_data;
    assign mem_exc       = r_mem_exc;
    assign mem_exc_cause = r_exc_cause;

    assign w_timeout_hit = (r_cnt == CNT_W'(DMEM_TIMEOUT - 1));

    // Classify the incoming instruction and build byte enables / lane data
    always_comb begin
        w_is_mem     = ex_mem_read | ex_mem_write;
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_lane_wdata = ex_wdata;

        if (ex_mem_read && ex_mem_write) begin
            w_illegal = 1'b1;
        end else if (ex_mem_read) begin
            case (ex_funct3)
                3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
                default:                w_illegal = 1'b0;
            endcase
        end else if (ex_mem_write) begin
            w_illegal = (ex_funct3 >= 3'b011);
        end

        case (ex_funct3[1:0])
            2'b00: begin
                w_be         = 4'b0001 << ex_alu_result[1:0];
                w_lane_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = ex_alu_result[0];
                w_be         = 4'b0011 << {ex_alu_result[1], 1'b0};
                w_lane_wdata = {2{ex_wdata[15:0]}};
            end
            2'b10: begin
                w_misaligned = |ex_alu_result[1:0];
            end
            default: begin
                w_misaligned = 1'b0;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_ld_byte = dmem_rdata[7:0];
            2'd1:    w_ld_byte = dmem_rdata[15:8];
            2'd2:    w_ld_byte = dmem_rdata[23:16];
            default: w_ld_byte = dmem_rdata[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (r_funct3)
            3'b000:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_load_data = {24'd0, w_ld_byte};
            3'b101:  w_load_data = {16'd0, w_ld_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt        = r_state;
        w_dmem_req_nxt     = r_dmem_req;
        w_dmem_we_nxt      = r_dmem_we;
        w_dmem_addr_nxt    = r_dmem_addr;
        w_dmem_be_nxt      = r_dmem_be;
        w_dmem_wdata_nxt   = r_dmem_wdata;
        w_wb_valid_nxt     = 1'b0;
        w_wb_rd_nxt        = '0;
        w_wb_reg_write_nxt = 1'b0;
        w_wb_data_nxt      = '0;
        w_mem_exc_nxt      = 1'b0;
        w_exc_cause_nxt    = CAUSE_NONE;
        w_cnt_nxt          = r_cnt;
        w_funct3_nxt       = r_funct3;
        w_addr_lo_nxt      = r_addr_lo;
        w_rd_nxt           = r_rd;
        w_reg_write_nxt    = r_reg_write;
        w_is_load_nxt      = r_is_load;

        case (r_state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!w_is_mem) begin
                        w_wb_valid_nxt     = 1'b1;
                        w_wb_data_nxt      = ex_alu_result;
                        w_wb_rd_nxt        = ex_rd;
                        w_wb_reg_write_nxt = ex_reg_write;
                    end else if (w_illegal || w_misaligned) begin
                        w_wb_valid_nxt  = 1'b1;
                        w_wb_rd_nxt     = ex_rd;
                        w_mem_exc_nxt   = 1'b1;
                        w_exc_cause_nxt = w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALGN;
                    end else begin
                        w_state_nxt      = S_ACCESS;
                        w_dmem_req_nxt   = 1'b1;
                        w_dmem_we_nxt    = ex_mem_write;
                        w_dmem_addr_nxt  = {ex_alu_result[31:2], 2'b00};
                        w_dmem_be_nxt    = w_be;
                        w_dmem_wdata_nxt = ex_mem_write ? w_lane_wdata : '0;
                        w_cnt_nxt        = '0;
                        w_funct3_nxt     = ex_funct3;
                        w_addr_lo_nxt    = ex_alu_result[1:0];
                        w_rd_nxt         = ex_rd;
                        w_reg_write_nxt  = ex_reg_write;
                        w_is_load_nxt    = ex_mem_read;
                    end
                end
            end

            S_ACCESS: begin
                if (dmem_ack || w_timeout_hit) begin
                    // Ack on the terminal cycle takes priority over the timeout
                    w_state_nxt      = S_IDLE;
                    w_dmem_req_nxt   = 1'b0;
                    w_dmem_we_nxt    = 1'b0;
                    w_dmem_addr_nxt  = '0;
                    w_dmem_be_nxt    = '0;
                    w_dmem_wdata_nxt = '0;
                    w_cnt_nxt        = '0;
                    w_wb_valid_nxt   = 1'b1;
                    w_wb_rd_nxt      = r_rd;
                    if (dmem_ack) begin
                        w_wb_reg_write_nxt = r_is_load & r_reg_write;
                        w_wb_data_nxt      = r_is_load ? w_load_data : '0;
                    end else begin
                        w_mem_exc_nxt   = 1'b1;
                        w_exc_cause_nxt = CAUSE_TIMEOUT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, counter and captured-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_be      <= '0;
            r_dmem_wdata   <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= '0;
            r_mem_exc      <= 1'b0;
            r_exc_cause    <= CAUSE_NONE;
            r_cnt          <= '0;
            r_funct3       <= '0;
            r_addr_lo      <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_is_load      <= 1'b0;
        end else begin
            r_dmem_req     <= w_dmem_req_nxt;
            r_dmem_we      <= w_dmem_we_nxt;
            r_dmem_addr    <= w_dmem_addr_nxt;
            r_dmem_be      <= w_dmem_be_nxt;
            r_dmem_wdata   <= w_dmem_wdata_nxt;
            r_wb_valid     <= w_wb_valid_nxt;
            r_wb_rd        <= w_wb_rd_nxt;
            r_wb_reg_write <= w_wb_reg_write_nxt;
            r_wb_data      <= w_wb_data_nxt;
            r_mem_exc      <= w_mem_exc_nxt;
            r_exc_cause    <= w_exc_cause_nxt;
            r_cnt          <= w_cnt_nxt;
            r_funct3       <= w_funct3_nxt;
            r_addr_lo      <= w_addr_lo_nxt;
            r_rd           <= w_rd_nxt;
            r_reg_write    <= w_reg_write_nxt;
            r_is_load      <= w_is_load_nxt;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage between the execute stage (ALU result, rs2 data, immediate mux) and register writeback. Takes one instruction at a time, issues word-aligned requests with byte enables to data memory over a req/ack handshake, and formats load data (sign/zero extension, lane select). Stalls execute while a request is outstanding, and flags misaligned, illegal and timed-out accesses.

## Interface
- DMEM_TIMEOUT, 16: max cycles dmem_req stays high without dmem_ack before abort (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage accepts this cycle; combinational, high only in IDLE
- ex_alu_result  in  32  effective address, or result for non-memory ops
- ex_wdata  in  32  store data (rs2)
- ex_funct3  in  3  access size/sign
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- dmem_req  out  1  request; held until ack or timeout
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_ack  in  1  completion; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_rd  out  5  destination
- wb_reg_write  out  1  write enable; forced 0 on any exception
- wb_data  out  32  writeback value
- mem_exc  out  1  one-cycle pulse, coincident with wb_valid
- mem_exc_cause  out  2  01 misaligned, 10 illegal, 11 bus timeout; 00 when mem_exc=0

## Operation
- States: IDLE, ACCESS.
- Accept occurs when ex_valid && ex_ready. Inputs are captured on acceptance.
- Non-memory op (read=write=0): next cycle wb_valid=1, wb_data=ex_alu_result, wb_rd and wb_reg_write are passed through. State stays IDLE.
- Illegal: read and write both 1, load funct3 ∈ {011,110,111}, or store funct3 ≥ 011. No memory access; next cycle wb_valid=1, mem_exc=1, cause 10.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. No access; next cycle wb_valid=1, mem_exc=1, cause 01.
- Legal memory op → ACCESS. dmem_req=1 from the next cycle, with registered dmem_we, dmem_addr, dmem_be and dmem_wdata held stable until it drops.
- Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load data: lane select by a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
- ACCESS with dmem_ack: drop req in the next cycle and go to IDLE. In that cycle wb_valid=1, wb_data = formatted load (0 for stores), wb_reg_write = captured value (stores always 0).
- Timeout: a counter clears on entering ACCESS and increments each cycle req is high without ack. If it reaches DMEM_TIMEOUT-1 with no ack, the next cycle has req=0, IDLE, wb_valid=1, mem_exc=1, cause 11, wb_reg_write=0.
- Ack on the terminal timeout cycle wins (normal completion).
- dmem_ack outside ACCESS is ignored.
- No backpressure from writeback; wb_* are registered and valid only while wb_valid=1. Otherwise wb_data, wb_rd and wb_reg_write read as 0.

## Timing
- Reset (async, immediate): state IDLE, dmem_req/we=0, dmem_addr/be/wdata=0, wb_valid/rd/reg_write/data=0, mem_exc=0, cause=00, counter=0. ex_ready=1 while in reset.
- Non-memory/exception latency: accept at cycle N, wb_valid at N+1; back-to-back acceptance every cycle.
- Memory latency: accept N, dmem_req high N+1; ack at cycle K (≥N+1) → wb_valid K+1, ex_ready high at K+1, next accept earliest K+1.
- ex_ready low from N+1 until the cycle after ack or timeout.
- Reset mid-ACCESS drops dmem_req immediately. The instruction is discarded with no wb_valid.

## Test plan
- ADD result 0x0000_1234, rd=5, reg_write=1 → 1 cycle later wb_valid, wb_data=0x1234, wb_rd=5, no dmem_req.
- SB addr 0x103, wdata 0xAB → dmem_addr=0x100, be=1000, wdata=0xABABABAB, we=1; ack after 3 cycles → wb_valid with wb_reg_write=0 the following cycle.
- LB addr 0x102, rdata 0x0080_0000 → wb_data=0xFFFF_FF80; LBU same → 0x0000_0080; LH addr 0x102, rdata 0x8001_0000 → 0xFFFF_8001.
- LW addr 0x206 → no dmem_req; next cycle mem_exc=1, cause 01, wb_reg_write=0.
- LW, ack never arrives, DMEM_TIMEOUT=16 → req high exactly 16 cycles, then mem_exc cause 11. A late ack is ignored, and the next instruction is accepted normally.
- Load with funct3=011 → cause 10, no request. rst_n low during ACCESS → dmem_req=0 asynchronously, no wb_valid after release.
